// File: rtl/user_id_issuer_pkg.sv
// Shared widths, reserved code, FSM encoding and pointer wrap helper for the user-code issuer.
package user_id_issuer_pkg;

    localparam int USER_W   = 3;
    localparam int FIRST_ID = 1;
    localparam int NUM_IDS  = 2**USER_W - FIRST_ID;
    localparam int DEPTH    = 2**USER_W;

    localparam logic [USER_W-1:0] NO_USER    = '0;
    localparam logic [USER_W-1:0] FIRST_USER = USER_W'(FIRST_ID);
    localparam logic [USER_W-1:0] MAX_USER   = '1;
    localparam logic [USER_W-1:0] NUM_IDS_U  = USER_W'(NUM_IDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } state_t;

    // Advance a code, skipping the reserved range on wrap.
    function automatic logic [USER_W-1:0] next_ptr(input logic [USER_W-1:0] u);
        return (u == MAX_USER) ? FIRST_USER : u + 1'b1;
    endfunction

endpackage

// File: rtl/user_id_issuer_if.sv
// Request/grant/release bus between entry-interface FSMs (master) and the issuer (slave).
interface user_id_issuer_if;
    import user_id_issuer_pkg::*;

    logic              req;
    logic              gnt_valid;
    logic [USER_W-1:0] gnt_user;
    logic              gnt_deny;
    logic              rel_valid;
    logic [USER_W-1:0] rel_user;
    logic              rel_err;
    logic [USER_W-1:0] used_count;
    logic              full;

    modport master (
        output req, rel_valid, rel_user,
        input  gnt_valid, gnt_user, gnt_deny, rel_err, used_count, full
    );

    modport slave (
        input  req, rel_valid, rel_user,
        output gnt_valid, gnt_user, gnt_deny, rel_err, used_count, full
    );

endinterface

// File: rtl/user_id_issuer_bitmap.sv
// Occupancy bitmap of live user codes with release legality check and live-code count.
// Latency: set/clear effective at the clock edge; rel_err one cycle after the strobe.
// Backpressure: none, releases are accepted every cycle.
module user_id_issuer_bitmap
    import user_id_issuer_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              set_vld,
    input  logic [USER_W-1:0] set_user,
    input  logic              rel_vld,
    input  logic [USER_W-1:0] rel_user,
    input  logic [USER_W-1:0] cand_user,
    output logic              is_used,
    output logic              rel_err,
    output logic [USER_W-1:0] used_count
);

    logic [DEPTH-1:0] bitmap;
    logic             rel_legal;

    // Legality is judged on the pre-edge bitmap, so releasing the code being
    // granted this cycle is refused and the grant stands.
    assign rel_legal = rel_vld && (rel_user >= FIRST_USER) && bitmap[rel_user];
    assign is_used   = bitmap[cand_user];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bitmap     <= '0;
            used_count <= '0;
            rel_err    <= 1'b0;
        end else begin
            if (set_vld)
                bitmap[set_user] <= 1'b1;
            if (rel_legal)
                bitmap[rel_user] <= 1'b0;
            rel_err <= rel_vld && !rel_legal;
            case ({set_vld, rel_legal})
                2'b10: if (used_count != NUM_IDS_U) used_count <= used_count + 1'b1;
                2'b01: if (used_count != '0)        used_count <= used_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/user_id_issuer.sv
// Round-robin allocator of 3-bit user codes with release reclaim.
// Latency: grant 2..NUM_IDS+1 cycles after req sampled in IDLE; deny after NUM_IDS+1.
// Backpressure: none; req ignored outside IDLE, grant/deny are one-cycle pulses.
module user_id_issuer
    import user_id_issuer_pkg::*;
(
    input  logic             clock,
    input  logic             reset_n,
    user_id_issuer_if.slave  bus
);

    state_t            state;
    logic [USER_W-1:0] ptr;
    logic [USER_W-1:0] scan_cnt;
    logic [USER_W-1:0] gnt_user_q;
    logic              gnt_valid_q;
    logic              gnt_deny_q;
    logic              is_used;
    logic              rel_err;
    logic [USER_W-1:0] used_count;

    user_id_issuer_bitmap u_bitmap (
        .clock      (clock),
        .reset_n    (reset_n),
        .set_vld    (state == GRANT),
        .set_user   (gnt_user_q),
        .rel_vld    (bus.rel_valid),
        .rel_user   (bus.rel_user),
        .cand_user  (ptr),
        .is_used    (is_used),
        .rel_err    (rel_err),
        .used_count (used_count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            ptr         <= FIRST_USER;
            scan_cnt    <= '0;
            gnt_user_q  <= NO_USER;
            gnt_valid_q <= 1'b0;
            gnt_deny_q  <= 1'b0;
        end else begin
            gnt_valid_q <= 1'b0;
            gnt_deny_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req) begin
                        scan_cnt <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    // A full lap of used candidates leaves ptr back at its start.
                    if (scan_cnt == NUM_IDS_U) begin
                        gnt_deny_q <= 1'b1;
                        state      <= IDLE;
                    end else if (!is_used) begin
                        gnt_user_q <= ptr;
                        state      <= GRANT;
                    end else begin
                        ptr      <= next_ptr(ptr);
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                GRANT: begin
                    gnt_valid_q <= 1'b1;
                    ptr         <= next_ptr(gnt_user_q);
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt_valid  = gnt_valid_q;
    assign bus.gnt_user   = gnt_user_q;
    assign bus.gnt_deny   = gnt_deny_q;
    assign bus.rel_err    = rel_err;
    assign bus.used_count = used_count;
    assign bus.full       = (used_count == NUM_IDS_U);

endmodule

// File: tb/tb_user_id_issuer.sv
// Directed bench for user_id_issuer: allocation order, deny, reclaim, release errors, reset.
module tb_user_id_issuer;
    import user_id_issuer_pkg::*;

    logic clock;
    logic reset_n;
    int   checks;
    int   fails;
    logic seen;

    user_id_issuer_if bus();

    user_id_issuer dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Assumes req is held and the FSM is in IDLE: sample, latch, grant.
    task automatic grant_cycle(input int exp_user);
        step();
        step();
        check("gnt_early", 32'(bus.gnt_valid), 0);
        step();
        check("gnt_valid", 32'(bus.gnt_valid), 1);
        check("gnt_user", 32'(bus.gnt_user), 32'(exp_user));
    endtask

    initial begin
        checks        = 0;
        fails         = 0;
        reset_n       = 1'b0;
        bus.req       = 1'b0;
        bus.rel_valid = 1'b0;
        bus.rel_user  = '0;
        step();
        step();
        check("rst_gnt_valid", 32'(bus.gnt_valid), 0);
        check("rst_gnt_deny", 32'(bus.gnt_deny), 0);
        check("rst_rel_err", 32'(bus.rel_err), 0);
        check("rst_gnt_user", 32'(bus.gnt_user), 0);
        check("rst_used", 32'(bus.used_count), 0);
        check("rst_full", 32'(bus.full), 0);
        reset_n = 1'b1;

        // Fill the pool in order 1..7.
        bus.req = 1'b1;
        for (int i = 1; i <= 7; i++) grant_cycle(i);
        bus.req = 1'b0;
        check("fill_used", 32'(bus.used_count), 7);
        check("fill_full", 32'(bus.full), 1);

        // Pool exhausted: deny 8 cycles after the sample.
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 7; i++) begin
            step();
            seen = seen | bus.gnt_valid | bus.gnt_deny;
        end
        check("deny_early", 32'(seen), 0);
        step();
        check("deny_pulse", 32'(bus.gnt_deny), 1);
        check("deny_no_gnt", 32'(bus.gnt_valid), 0);
        check("deny_used", 32'(bus.used_count), 7);
        step();
        check("deny_one_cycle", 32'(bus.gnt_deny), 0);

        // Free code 4 and reclaim it after scanning past 1..3.
        bus.rel_valid = 1'b1;
        bus.rel_user  = 3'd4;
        step();
        bus.rel_valid = 1'b0;
        check("rel4_used", 32'(bus.used_count), 6);
        check("rel4_full", 32'(bus.full), 0);
        check("rel4_err", 32'(bus.rel_err), 0);
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        step();
        step();
        step();
        step();
        check("regnt_early", 32'(bus.gnt_valid), 0);
        step();
        check("regnt_valid", 32'(bus.gnt_valid), 1);
        check("regnt_user", 32'(bus.gnt_user), 4);
        check("regnt_used", 32'(bus.used_count), 7);

        // Illegal releases: reserved code, then an already-free code.
        bus.rel_valid = 1'b1;
        bus.rel_user  = 3'd0;
        step();
        bus.rel_valid = 1'b0;
        check("rel0_err", 32'(bus.rel_err), 1);
        step();
        check("rel0_err_clr", 32'(bus.rel_err), 0);
        check("rel0_used", 32'(bus.used_count), 7);
        bus.rel_valid = 1'b1;
        bus.rel_user  = 3'd5;
        step();
        check("rel5_legal_err", 32'(bus.rel_err), 0);
        check("rel5_used", 32'(bus.used_count), 6);
        step();
        bus.rel_valid = 1'b0;
        check("rel5_again_err", 32'(bus.rel_err), 1);
        check("rel5_again_used", 32'(bus.used_count), 6);
        step();
        check("rel5_err_clr", 32'(bus.rel_err), 0);

        // Free 3, take 5 (pointer sits there), then grant 3 while releasing 2.
        bus.rel_valid = 1'b1;
        bus.rel_user  = 3'd3;
        step();
        bus.rel_valid = 1'b0;
        check("rel3_used", 32'(bus.used_count), 5);
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        step();
        step();
        check("g5_valid", 32'(bus.gnt_valid), 1);
        check("g5_user", 32'(bus.gnt_user), 5);
        check("g5_used", 32'(bus.used_count), 6);
        bus.req = 1'b1;
        step();
        bus.req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("g3_latched", 32'(bus.gnt_user), 3);
        check("g3_early", 32'(bus.gnt_valid), 0);
        bus.rel_valid = 1'b1;
        bus.rel_user  = 3'd2;
        step();
        bus.rel_valid = 1'b0;
        check("g3_valid", 32'(bus.gnt_valid), 1);
        check("g3_user", 32'(bus.gnt_user), 3);
        check("g3_used_net", 32'(bus.used_count), 6);
        check("g3_rel_err", 32'(bus.rel_err), 0);
        check("g3_full", 32'(bus.full), 0);

        // Fresh start, three live codes, then reset in the middle of a scan.
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        bus.req = 1'b1;
        for (int i = 1; i <= 3; i++) grant_cycle(i);
        check("pre_rst_used", 32'(bus.used_count), 3);
        step();
        reset_n = 1'b0;
        #1;
        check("mid_rst_user", 32'(bus.gnt_user), 0);
        check("mid_rst_used", 32'(bus.used_count), 0);
        check("mid_rst_valid", 32'(bus.gnt_valid), 0);
        step();
        check("mid_rst_no_gnt", 32'(bus.gnt_valid), 0);
        reset_n = 1'b1;
        grant_cycle(1);
        bus.req = 1'b0;
        check("post_rst_used", 32'(bus.used_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/user_id_issuer.md
Name: user_id_issuer

Overview:
- Allocates 3-bit user codes to requesting entry interfaces and reclaims them on release.
- Supplies the ie*_user codes that the same-user comparator consumes downstream.
- Keeps an occupancy bitmap, so no code is handed out twice while it is live.
- Sits between the entry-interface control FSMs and the user-compare logic.

Parameters:
- USER_W, 3: user code width.
- FIRST_ID, 1: lowest issuable code. Codes below FIRST_ID are reserved ("no user") and are never granted.
- NUM_IDS, 2**USER_W - FIRST_ID (7): pool size. Derived; must not be overridden.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req  in  1  allocation request. Sampled only in IDLE.
- gnt_valid  out  1  one-cycle pulse: gnt_user holds a newly allocated code.
- gnt_user  out  USER_W  granted code. Held until the next grant.
- gnt_deny  out  1  one-cycle pulse: pool exhausted, request refused.
- rel_valid  in  1  release strobe, accepted in any state.
- rel_user  in  USER_W  code to release.
- rel_err  out  1  one-cycle pulse, the cycle after an illegal release.
- used_count  out  USER_W  number of live codes, 0..NUM_IDS.
- full  out  1  high when used_count == NUM_IDS.

Behaviour:
- Reset (async, reset_n=0):
  - Bitmap all free; scan pointer ptr=FIRST_ID; state=IDLE.
  - gnt_valid=0, gnt_deny=0, rel_err=0, gnt_user=0, used_count=0, full=0.
- State IDLE:
  - If req=1, load scan_cnt=0 and go to SCAN.
  - If req=0, stay.
- State SCAN (one candidate per cycle; candidate=ptr):
  - Candidate free: latch cand into gnt_user and go to GRANT.
  - Candidate used: ptr advances, wrapping 2**USER_W-1 -> FIRST_ID; scan_cnt++.
  - scan_cnt reaches NUM_IDS with nothing free: pulse gnt_deny, go to IDLE. ptr is unchanged overall, i.e. it returns to its start value after the full lap.
- State GRANT (single cycle):
  - Set bitmap[gnt_user]; pulse gnt_valid; ptr=gnt_user+1 with wrap; go to IDLE.
- Latency from req sampled in IDLE:
  - Best case: gnt_valid 2 cycles later.
  - Worst successful case: NUM_IDS+1 cycles.
  - Deny: NUM_IDS+1 cycles.
- Round-robin: a freshly released code is not reissued until the pointer laps to it.
- req is ignored outside IDLE. Dropping req mid-scan does not abort; the requester must accept the grant or release it.
- Release, registered and effective at the clock edge:
  - Legal when FIRST_ID <= rel_user and bitmap[rel_user]=1. The bit is cleared.
  - Illegal when rel_user is reserved or already free. Bitmap is unchanged and rel_err pulses the next cycle.
- Simultaneous events:
  - Release and GRANT in the same cycle, different codes: both apply; used_count is unchanged net.
  - Release of the code being granted in its GRANT cycle: illegal, because the code was free. Grant wins and rel_err pulses.
  - Release during SCAN: the bitmap update is visible to the next candidate check. A release at the current candidate is seen the following cycle only if ptr wraps back to it.
- used_count is +1 on a grant and -1 on a legal release; it never wraps. full is combinational from used_count.
- Reset asserted mid-SCAN or mid-GRANT: immediate return to reset state. No grant pulse is emitted.

Decomposition:
- Shared package:
  - USER_W, FIRST_ID, derived NUM_IDS.
  - State encoding constants: IDLE=2'd0, SCAN=2'd1, GRANT=2'd2.
  - Reserved-code constant NO_USER=0.
- One natural sub-module, user_id_bitmap:
  - Owns the occupancy register, the set/clear/legality check, and used_count.
  - Outputs: is_used for the candidate, plus rel_err.
- The FSM and pointer stay in the top module.

Test Plan:
- Reset, then req held for 7 grant cycles -> gnt_user sequence 1,2,3,4,5,6,7; each gnt_valid arrives 2 cycles after its IDLE sample; used_count=7; full=1.
- Pool full, req=1 -> gnt_deny exactly 8 cycles after sampling; no gnt_valid; bitmap unchanged; used_count=7.
- Full, release code 4, then req -> grant returns 4 after the scan passes 1..3 (ptr was 1 after wrap); used_count back to 7.
- Release code 0, then release code 5 while 5 is free -> rel_err pulses once each, one cycle after the strobe; used_count unchanged.
- Grant of code 3 in GRANT while releasing code 2 (live) the same cycle -> both take effect; used_count unchanged net; rel_err=0.
- reset_n asserted during SCAN with 3 codes live -> all outputs 0 immediately; next req is granted code 1.
